// File: rtl/tx_word_sched.sv
// tx_word_sched: round-robin scheduler for two 32-bit requesters, serialized MSB byte first.
// Define TX_WORD_SCHED_IDLE_FILL_EN to drive IDLE_BYTE with idle_out=1 while idle.
module tx_word_sched #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        gnt_b,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        first_out,
  output logic        src_out,
  output logic        idle_out
);

`ifdef TX_WORD_SCHED_IDLE_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  localparam logic [7:0] IDLE_DATA = IDLE_BYTE & {8{FILL_EN}};

  logic [1:0]  r_phase;
  logic [31:0] r_hold;
  logic        r_last;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_first;
  logic        r_src;
  logic        r_idle;

  logic        w_ready;
  logic        w_gnt_a;
  logic        w_gnt_b;
  logic [31:0] w_word;
  logic [7:0]  w_byte;

  // r_last names the previous winner; a tie goes to the other side
  assign w_ready = !reset && (r_phase == 2'd0);
  assign w_gnt_a = w_ready && req_a && (!req_b || r_last);
  assign w_gnt_b = w_ready && req_b && (!req_a || !r_last);
  assign w_word  = w_gnt_b ? data_b : data_a;

  always_comb begin
    w_byte = r_hold[7:0];
    case (r_phase)
      2'd3:    w_byte = r_hold[23:16];
      2'd2:    w_byte = r_hold[15:8];
      default: w_byte = r_hold[7:0];
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_phase <= 2'd0;
      r_hold  <= 32'd0;
      r_last  <= 1'b1;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_src   <= 1'b0;
      r_idle  <= 1'b0;
    end else if (w_gnt_a || w_gnt_b) begin
      r_phase <= 2'd3;
      r_hold  <= w_word;
      r_last  <= w_gnt_b;
      r_data  <= w_word[31:24];
      r_valid <= 1'b1;
      r_first <= 1'b1;
      r_src   <= w_gnt_b;
      r_idle  <= 1'b0;
    end else if (r_phase != 2'd0) begin
      r_phase <= r_phase - 2'd1;
      r_data  <= w_byte;
      r_valid <= 1'b1;
      r_first <= 1'b0;
      r_idle  <= 1'b0;
    end else begin
      r_data  <= IDLE_DATA;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_idle  <= FILL_EN;
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign first_out = r_first;
  assign src_out   = r_src;
  assign idle_out  = r_idle;

endmodule

// File: tb/tb_tx_word_sched.sv
// tb_tx_word_sched: directed and random stimulus against a byte-queue reference.
// Follows TX_WORD_SCHED_IDLE_FILL_EN to pick the expected idle behaviour.
module tb_tx_word_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        gnt_a, gnt_b;
  logic [7:0]  data_out;
  logic        valid_out, first_out, src_out, idle_out;

  always #5 clk = ~clk;

  tx_word_sched dut (
    .clk_4f    (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .data_out  (data_out),
    .valid_out (valid_out),
    .first_out (first_out),
    .src_out   (src_out),
    .idle_out  (idle_out)
  );

`ifdef TX_WORD_SCHED_IDLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference: bytes still owed for the word in flight, plus expected outputs
  logic [7:0] owed[$];
  bit         m_last = 1'b1;
  logic [7:0] m_data;
  bit         m_valid, m_first, m_src, m_idle;
  bit         g_a, g_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ra, input logic [31:0] da,
                      input bit rb, input logic [31:0] db);
    bit ready;
    bit ea;
    bit eb;
    logic [31:0] w;
    @(negedge clk);
    reset  = rst;
    req_a  = ra;
    data_a = da;
    req_b  = rb;
    data_b = db;
    #1;
    ready = !rst && (owed.size() == 0);
    ea = ready && ra && (!rb || m_last);
    eb = ready && rb && (!ra || !m_last);
    chk("gnt_a", 32'(gnt_a), 32'(ea));
    chk("gnt_b", 32'(gnt_b), 32'(eb));
    if (rst) begin
      owed.delete();
      m_last = 1'b1; m_data = 8'h00; m_valid = 0;
      m_first = 0; m_src = 0; m_idle = 0;
    end else if (ea || eb) begin
      w = ea ? da : db;
      owed.delete();
      owed.push_back(w[23:16]);
      owed.push_back(w[15:8]);
      owed.push_back(w[7:0]);
      m_data = w[31:24]; m_valid = 1; m_first = 1;
      m_src = eb; m_idle = 0; m_last = eb;
    end else if (owed.size() > 0) begin
      m_data = owed.pop_front();
      m_valid = 1; m_first = 0; m_idle = 0;
    end else begin
      m_data = FILL ? 8'hBC : 8'h00;
      m_valid = 0; m_first = 0; m_idle = FILL;
    end
    g_a = ea;
    g_b = eb;
    @(posedge clk);
    #1;
    chk("data_out",  32'(data_out),  32'(m_data));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("first_out", 32'(first_out), 32'(m_first));
    chk("src_out",   32'(src_out),   32'(m_src));
    chk("idle_out",  32'(idle_out),  32'(m_idle));
  endtask

  initial begin
    bit ra, rb, rst;
    logic [31:0] da, db;
    bit held_a, held_b;

    // reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_data", 32'(data_out), 32'h0);

    // single word from A
    step(0, 1, 32'hA1B2C3D4, 0, 0);
    chk("single_gnt", 32'(gnt_a), 32'h0);
    chk("single_b0", 32'(data_out), 32'hA1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("single_b3", 32'(data_out), 32'hD4);

    // idle for three cycles
    repeat (3) step(0, 0, 0, 0, 0);
    chk("idle_valid", 32'(valid_out), 32'h0);

    // continuous contention alternates sources
    repeat (16) step(0, 1, 32'h11223344, 1, 32'h55667788);
    repeat (4) step(0, 0, 0, 0, 0);

    // B request arriving mid-word waits, then follows without a bubble
    step(0, 1, 32'hCAFEF00D, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0BADBEEF);
    step(0, 0, 0, 1, 32'h0BADBEEF);
    step(0, 0, 0, 1, 32'h0BADBEEF);
    chk("stab_gnt_b", 32'(g_b), 32'h1);
    repeat (4) step(0, 0, 0, 0, 0);

    // reset after the second byte, then re-present the word
    step(0, 0, 0, 1, 32'hB1B2B3B4);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("midrst_valid", 32'(valid_out), 32'h0);
    step(0, 0, 0, 1, 32'hB1B2B3B4);
    chk("restart_b0", 32'(data_out), 32'hB1);
    repeat (4) step(0, 0, 0, 0, 0);

    // tie directly after reset: A first, then B
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h01020304, 1, 32'h05060708);
    chk("tie_first_a", 32'(g_a), 32'h1);
    repeat (3) step(0, 1, 32'h01020304, 1, 32'h05060708);
    step(0, 1, 32'h01020304, 1, 32'h05060708);
    chk("tie_next_b", 32'(g_b), 32'h1);

    // random traffic; data held stable while a request waits
    ra = 0; rb = 0; da = 0; db = 0;
    held_a = 0; held_b = 0;
    for (int i = 0; i < 600; i++) begin
      if (held_a && !g_a && ($urandom_range(7) != 0)) ra = 1;
      else begin ra = $urandom_range(1); da = $urandom; end
      if (held_b && !g_b && ($urandom_range(7) != 0)) rb = 1;
      else begin rb = $urandom_range(1); db = $urandom; end
      rst = ($urandom_range(49) == 0);
      step(rst, ra, da, rb, db);
      held_a = ra && !rst;
      held_b = rb && !rst;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
